// File: rtl/motion_pkg.sv
// Shared definitions for the motion-control blocks: FSM encoding and default widths.
package motion_pkg;

    localparam int W_PER = 32;
    localparam int W_JRK = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEL  = 3'd1;
    localparam logic [2:0] S_CRUISE = 3'd2;
    localparam logic [2:0] S_DECEL  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/rising_edge_det.sv
// Registered rising-edge detector: pulse is high in the cycle d first reads 1.
module rising_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= d;
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/scurve_period_gen.sv
// Jerk-limited period shaper feeding the PWM: accelerates, cruises and decelerates
// one step at a time, counting steps from the PWM pulse fed back on step_in.
module scurve_period_gen
    import motion_pkg::*;
#(
    parameter int W_PER = motion_pkg::W_PER,
    parameter int W_JRK = motion_pkg::W_JRK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W_PER-1:0] steps_total,
    input  logic [W_PER-1:0] period_init,
    input  logic [W_PER-1:0] period_min,
    input  logic [W_JRK-1:0] jerk,
    input  logic [W_JRK-1:0] dmax,
    input  logic             step_in,
    output logic [W_PER-1:0] f,
    output logic             pwm_reset,
    output logic             busy,
    output logic             done,
    output logic [W_PER-1:0] steps_done,
    output logic [2:0]       state
);

    logic             step_edge;
    logic [W_PER-1:0] tot_q, init_q, min_q, jerk_q, dmax_q;
    logic [W_PER-1:0] d_q, acc_cnt;
    logic [W_PER-1:0] sd_next, rem, d_inc, d_sat, f_sub, f_acc, f_dec;
    logic [W_PER:0]   f_sum;

    rising_edge_det u_step_edge (
        .clk   (clk),
        .reset (reset),
        .d     (step_in),
        .pulse (step_edge)
    );

    assign pwm_reset = (state == S_IDLE) || (state == S_DONE);
    assign busy      = ~pwm_reset;

    // Next-step arithmetic; f never drops below the latched minimum or rises above init.
    always_comb begin
        sd_next = steps_done + W_PER'(1);
        rem     = tot_q - sd_next;
        d_inc   = d_q + jerk_q;
        d_sat   = (d_inc > dmax_q) ? dmax_q : d_inc;
        f_sub   = (f > d_sat) ? (f - d_sat) : '0;
        f_acc   = (f_sub < min_q) ? min_q : f_sub;
        f_sum   = {1'b0, f} + {1'b0, d_sat};
        f_dec   = (f_sum > {1'b0, init_q}) ? init_q : f_sum[W_PER-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            f          <= '0;
            d_q        <= '0;
            steps_done <= '0;
            acc_cnt    <= '0;
            done       <= 1'b0;
            tot_q      <= '0;
            init_q     <= '0;
            min_q      <= '0;
            jerk_q     <= '0;
            dmax_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tot_q  <= steps_total;
                        init_q <= period_init;
                        min_q  <= (period_min < period_init) ? period_min : period_init;
                        jerk_q <= {{(W_PER-W_JRK){1'b0}}, jerk};
                        dmax_q <= {{(W_PER-W_JRK){1'b0}}, dmax};
                        if (steps_total == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            f          <= period_init;
                            d_q        <= '0;
                            steps_done <= '0;
                            acc_cnt    <= '0;
                            state      <= S_ACCEL;
                        end
                    end
                end
                S_ACCEL: begin
                    if (step_edge) begin
                        steps_done <= sd_next;
                        if (rem == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (rem <= acc_cnt) begin
                            state <= S_DECEL;
                            d_q   <= '0;
                        end else if (f == min_q) begin
                            state <= S_CRUISE;
                        end else begin
                            d_q     <= d_sat;
                            f       <= f_acc;
                            acc_cnt <= acc_cnt + W_PER'(1);
                        end
                    end
                end
                S_CRUISE: begin
                    if (step_edge) begin
                        steps_done <= sd_next;
                        if (rem == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (rem <= acc_cnt) begin
                            state <= S_DECEL;
                            d_q   <= '0;
                        end
                    end
                end
                S_DECEL: begin
                    if (step_edge) begin
                        steps_done <= sd_next;
                        if (rem == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            d_q <= d_sat;
                            f   <= f_dec;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scurve_period_gen.sv
// Directed bench for scurve_period_gen: each step edge pushes its expected f/steps/state,
// a negedge monitor pops and compares once the DUT has registered that edge.
module tb_scurve_period_gen;

    localparam logic [2:0] T_IDLE   = 3'd0;
    localparam logic [2:0] T_ACCEL  = 3'd1;
    localparam logic [2:0] T_CRUISE = 3'd2;
    localparam logic [2:0] T_DECEL  = 3'd3;
    localparam logic [2:0] T_DONE   = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] steps_total = '0;
    logic [31:0] period_init = '0;
    logic [31:0] period_min = '0;
    logic [15:0] jerk = '0;
    logic [15:0] dmax = '0;
    logic        step_in = 1'b0;
    logic [31:0] f;
    logic        pwm_reset;
    logic        busy;
    logic        done;
    logic [31:0] steps_done;
    logic [2:0]  state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    logic busy_seen = 1'b0;
    logic [66:0] exp_q[$];

    scurve_period_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .steps_total (steps_total),
        .period_init (period_init),
        .period_min  (period_min),
        .jerk        (jerk),
        .dmax        (dmax),
        .step_in     (step_in),
        .f           (f),
        .pwm_reset   (pwm_reset),
        .busy        (busy),
        .done        (done),
        .steps_done  (steps_done),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Monitor: mirrors the sampling of step_in to know when a registered update is due.
    logic edge_hit = 1'b0;
    logic smp_last = 1'b0;
    always @(posedge clk) begin
        edge_hit <= step_in & ~smp_last;
        smp_last <= step_in;
    end

    always @(negedge clk) begin
        logic [66:0] e;
        logic [66:0] got;
        if (done) done_cnt++;
        if (busy) busy_seen = 1'b1;
        if (edge_hit) begin
            vec_cnt++;
            got = {f, steps_done, state};
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL edge_unexpected: got f=%0d steps=%0d state=%0d, required no edge", f, steps_done, state);
            end else begin
                e = exp_q.pop_front();
                if (got !== e)  begin
                    err_cnt++;
                    $display("FAIL edge_update: got f=%0d steps=%0d state=%0d, required f=%0d steps=%0d state=%0d",
                             f, steps_done, state, e[66:35], e[34:3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic apply_start(input logic [31:0] tot, input logic [31:0] init, input logic [31:0] pmin,
                               input logic [15:0] jk, input logic [15:0] dm);
        @(negedge clk);
        steps_total = tot;
        period_init = init;
        period_min  = pmin;
        jerk        = jk;
        dmax        = dm;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic step_exp(input logic [31:0] ef, input logic [31:0] esd, input logic [2:0] est);
        exp_q.push_back({ef, esd, est});
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic step_hold_exp(input logic [31:0] ef, input logic [31:0] esd, input logic [2:0] est);
        exp_q.push_back({ef, esd, est});
        step_in = 1'b1;
        repeat (4) @(negedge clk);
        step_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int d0;
        logic [31:0] acc_f [5];
        logic [31:0] dec_f [4];
        acc_f[0] = 950; acc_f[1] = 850; acc_f[2] = 700; acc_f[3] = 500; acc_f[4] = 400;
        dec_f[0] = 450; dec_f[1] = 550; dec_f[2] = 700; dec_f[3] = 900;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'(T_IDLE));
        check("rst_f", f, 0);
        check("rst_steps", steps_done, 0);
        check("rst_pwm_reset", 32'(pwm_reset), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        // Full profile, with a stray start in the middle of cruise.
        apply_start(40, 1000, 400, 50, 200);
        check("full_start_f", f, 1000);
        check("full_start_busy", 32'(busy), 1);
        check("full_start_pwm_reset", 32'(pwm_reset), 0);
        d0 = done_cnt;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 5)       step_exp(acc_f[k-1], k, T_ACCEL);
            else if (k <= 34) step_exp(400, k, T_CRUISE);
            else if (k == 35) step_exp(400, k, T_DECEL);
            else if (k <= 39) step_exp(dec_f[k-36], k, T_DECEL);
            else              step_exp(900, k, T_DONE);
            if (k == 20) begin
                apply_start(5, 3000, 10, 999, 999);
                check("cruise_start_ignored", 32'(state), 32'(T_CRUISE));
            end
        end
        check("full_done_once", done_cnt - d0, 1);
        check("full_steps_done", steps_done, 40);
        check("full_pwm_reset", 32'(pwm_reset), 1);
        check("full_idle", 32'(state), 32'(T_IDLE));

        // Short move, second step held high for several cycles.
        d0 = done_cnt;
        apply_start(6, 1000, 400, 50, 200);
        step_exp(950, 1, T_ACCEL);
        step_hold_exp(850, 2, T_ACCEL);
        step_exp(700, 3, T_ACCEL);
        step_exp(700, 4, T_DECEL);
        step_exp(750, 5, T_DECEL);
        step_exp(750, 6, T_DONE);
        check("short_done_once", done_cnt - d0, 1);
        check("short_steps_done", steps_done, 6);

        // Minimum slower than init: clamped, cruise from the first step.
        d0 = done_cnt;
        apply_start(5, 1000, 2000, 50, 200);
        step_exp(1000, 1, T_CRUISE);
        for (int k = 2; k <= 4; k++) step_exp(1000, k, T_CRUISE);
        step_exp(1000, 5, T_DONE);
        check("clamp_done_once", done_cnt - d0, 1);

        // Zero-length move.
        busy_seen = 1'b0;
        d0 = done_cnt;
        apply_start(0, 777, 100, 50, 200);
        check("zero_done", 32'(done), 1);
        check("zero_state", 32'(state), 32'(T_DONE));
        check("zero_pwm_reset", 32'(pwm_reset), 1);
        check("zero_f_held", f, 1000);
        @(negedge clk);
        check("zero_done_cleared", 32'(done), 0);
        check("zero_busy_never", 32'(busy_seen), 0);
        check("zero_done_once", done_cnt - d0, 1);

        // Reset in the middle of acceleration.
        apply_start(40, 1000, 400, 50, 200);
        step_exp(950, 1, T_ACCEL);
        step_exp(850, 2, T_ACCEL);
        step_exp(700, 3, T_ACCEL);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", 32'(state), 32'(T_IDLE));
        check("midrst_f", f, 0);
        check("midrst_steps", steps_done, 0);
        check("midrst_pwm_reset", 32'(pwm_reset), 1);
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);

        // Steps while idle are not counted.
        for (int k = 0; k < 3; k++) step_exp(0, 0, T_IDLE);
        check("idle_steps_unchanged", steps_done, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/scurve_period_gen.md
Name: scurve_period_gen

Overview:
- Upstream stage of the PWM step generator.
- Produces the 32-bit period word `f` consumed by the PWM, plus a `pwm_reset` hold signal.
- Shapes `f` step by step into an S-curve-like move: jerk-limited acceleration, then cruise, then jerk-limited deceleration, over a commanded number of steps.
- Counts steps by detecting rising edges of the PWM `pulse` output, which is fed back to this block.

Parameters:
- W_PER, 32, width of period words and step counters.
- W_JRK, 16, width of the jerk and dmax inputs (zero-extended internally to W_PER).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- start  input  1  single-cycle move request; sampled only in IDLE.
- steps_total  input  W_PER  number of steps in the move.
- period_init  input  W_PER  start/end (slowest) period, in clk cycles.
- period_min  input  W_PER  cruise (fastest) period.
- jerk  input  W_JRK  per-step increment of the period delta d.
- dmax  input  W_JRK  ceiling on d.
- step_in  input  1  PWM `pulse` fed back; each rising edge is one step.
- f  output  W_PER  period word to the PWM.
- pwm_reset  output  1  drives the PWM `reset`.
- busy  output  1  move in progress.
- done  output  1  one-cycle completion strobe.
- steps_done  output  W_PER  steps counted in the current or last move.

Behaviour:
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Reset values (synchronous reset): state=IDLE, f=0, d=0, steps_done=0, acc_cnt=0, step_prev=0, done=0.
- Combinational outputs from state:
  - pwm_reset=1 and busy=0 in IDLE and DONE.
  - pwm_reset=0 and busy=1 in ACCEL, CRUISE and DECEL.
- Edge detection: step_prev is registered from step_in every cycle; edge = step_in & ~step_prev.
  - Edges are ignored in IDLE and DONE.
- Register latency: every update triggered by an edge appears on f and steps_done in the cycle after the edge cycle.
- IDLE + start:
  - Latch all inputs.
  - Effective period_min = min(period_min, period_init).
  - If steps_total == 0: go to DONE without asserting busy.
  - Otherwise: f=period_init, d=0, steps_done=0, acc_cnt=0, go to ACCEL.
- Rule applied on each edge in a running state:
  - steps_done += 1, and rem = steps_total − new steps_done.
  - Checks are evaluated in the order listed for each state; the first match applies.
- ACCEL:
  - rem==0 → DONE.
  - Else rem ≤ acc_cnt → DECEL with d=0; f unchanged on this edge.
  - Else f==period_min → CRUISE.
  - Else d = min(d+jerk, dmax); f = max(f−d, period_min), saturating so the subtraction never underflows; acc_cnt += 1.
- CRUISE:
  - rem==0 → DONE.
  - Else rem ≤ acc_cnt → DECEL with d=0.
  - Else hold.
- DECEL:
  - rem==0 → DONE.
  - Else d = min(d+jerk, dmax); f = min(f+d, period_init), using a W_PER+1-bit sum before clamping.
- DONE: done=1 for exactly one cycle, then IDLE. f and steps_done hold their values.
- start while busy or in DONE is ignored; no queuing.
- reset mid-move returns to IDLE within one cycle: pwm_reset=1, f=0, and no done strobe.
- An edge in the same cycle as a state entry is processed by the rules of the old state.

Decomposition:
- Shared package `motion_pkg`:
  - state encoding localparams (IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, DONE=4)
  - default widths W_PER and W_JRK.
- One sub-module, `rising_edge_det` (clk, reset, d, pulse), instantiated for step_in.
- Saturating add/subtract is kept inline.

Test Plan:
- Full profile: init=1000, min=400, jerk=50, dmax=200, total=40, with a PWM in loop → f sequence 1000, 950, 850, 700, 500, 400.
  - CRUISE is entered at edge 6.
  - DECEL is entered at edge 35 with f=400, then f = 450, 550, 700, 900.
  - done pulses once after edge 40; steps_done=40; pwm_reset=1.
- Short move: same params, total=6 → f = 950, 850, 700.
  - DECEL is entered at edge 4.
  - f=750 after edge 5.
  - DONE after edge 6; CRUISE is never entered.
- Zero move: total=0, start → done=1 one cycle later, busy never 1, pwm_reset stays 1, f unchanged.
- Reset mid-ACCEL after edge 3 → next cycle state=IDLE, f=0, steps_done=0, pwm_reset=1, no done strobe.
- Ignored inputs:
  - start asserted during CRUISE has no effect.
  - step_in toggling in IDLE leaves steps_done unchanged.
  - step_in held high produces a single count.
- Clamp: period_min=2000 > period_init=1000, total=5 → f stays 1000 for all steps; done after edge 5.
